id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register plus EX-side operand assembly for the 5-stage MIPS core. Sits directly
//  upstream of the ALU: captures decoded ID fields, forwards MEM/WB results, and drives ALU in1/in2/
//  ALUCtl/Sign. Detects load-use hazards and inserts bubbles on stall/flush.
// PARAMETERS
//  DW      32  datapath width (ALU operand/result width)
//  RW      5   register-address width
// PORTS
//  clk            in   1   core clock, all state on rising edge
//  reset          in   1   asynchronous, active-high
//  id_valid       in   1   ID holds a real instruction
//  id_rs_data     in   DW  regfile read port 1
//  id_rt_data     in   DW  regfile read port 2
//  id_rs_addr     in   RW  / id_rt_addr in RW / id_rd_addr in RW: source and destination addresses
//  id_uses_rs     in   1   / id_uses_rt in 1: instruction reads rs / rt (for hazard check)
//  id_imm16       in   16  instruction immediate
//  id_shamt       in   5   shift amount field
//  id_ALUCtl      in   5   / id_Sign in 1: ALU op code and signed-compare select
//  id_ALUSrc1     in   1   1: in1 = zero-extended shamt
//  id_ALUSrc2     in   1   1: in2 = extended immediate
//  id_ExtOp       in   1   1: sign-extend imm16, 0: zero-extend
//  id_LuOp        in   1   1: imm32 = {imm16,16'b0} (overrides ExtOp)
//  id_RegWrite    in   1   / id_MemRead in 1 / id_MemWrite in 1: pipeline controls
//  stall          in   1   hold ID/EX contents (downstream wait)
//  flush          in   1   replace ID/EX contents with bubble (branch/jump redirect)
//  mem_RegWrite   in   1   / mem_rd in RW / mem_result in DW: EX/MEM forwarding source
//  wb_RegWrite    in   1   / wb_rd in RW / wb_result in DW: MEM/WB forwarding source
//  ex_in1         out  DW  / ex_in2 out DW: ALU operands
//  ex_ALUCtl      out  5   / ex_Sign out 1: ALU control
//  ex_store_data  out  DW  forwarded rt value for SW
//  ex_rd          out  RW  / ex_RegWrite, ex_MemRead, ex_MemWrite, ex_valid out 1 each
//  load_use_stall out  1   combinational: upstream must hold PC and IF/ID this cycle
// BEHAVIOUR
//  - Reset: all registered fields 0; ex_valid/ex_RegWrite/ex_MemRead/ex_MemWrite = 0; ex_in1 =
//    ex_in2 = ex_store_data = 0; ex_ALUCtl = 5'b00000; load_use_stall = 0.
//  - Latency 1: ID fields sampled at edge N appear on ex_* after edge N.
//  - Per-edge priority: flush > stall > load_use_stall > normal load.
//    flush: bubble (valid, RegWrite, MemRead, MemWrite = 0; data fields 0). stall: hold all fields,
//    except held rs/rt data refresh from wb_result when wb_RegWrite & wb_rd!=0 & addr match.
//    load_use_stall: bubble loaded; ID is held upstream. Otherwise: load ID fields
//    (control bits gated by id_valid).
//  - imm32 computed in ID, registered: LuOp ? {imm16,16'h0} : ExtOp ? sext(imm16) : zext(imm16).
//  - Forwarding (combinational, per source operand): MEM if mem_RegWrite & mem_rd!=0 & mem_rd==addr;
//    else WB if same test on wb; else registered data. MEM wins over WB. Register 0 never forwarded.
//  - ex_in1 = ALUSrc1 ? {27'b0,shamt} : fwd_rs; ex_in2 = ALUSrc2 ? imm32 : fwd_rt;
//    ex_store_data = fwd_rt regardless of ALUSrc2.
//  - load_use_stall = ex_valid & ex_MemRead & ex_rd!=0 &
//    ((id_uses_rs & ex_rd==id_rs_addr) | (id_uses_rt & ex_rd==id_rt_addr)).
//    Deasserts the cycle after bubble insertion.
//  - Reset mid-operation: async clear, no partial state retained; flush during stall clears.
// STRUCTURE
//  - Shared package mips_pkg: ALUCtl encodings (AND 00000, OR 00001, ADD 00010, SUB 00110,
//    SLT 00111, NOR 01100, XOR 01101, SLL 10000, SRL 11000, SRA 11001), FWD_REG/FWD_MEM/FWD_WB
//    select codes, BUBBLE control constant.
//  - One sub-module fwd_sel (addr, reg data, mem/wb sources -> operand), instantiated for rs and rt.
// TESTING
//  1. addi: rs_data=5, imm16=16'hFFFF, ExtOp=1, ALUSrc2=1 -> next cycle ex_in1=5, ex_in2=32'hFFFF_FFFF.
//  2. lui imm16=16'h1234, LuOp=1 -> ex_in2=32'h1234_0000; sll shamt=3, ALUSrc1=1 -> ex_in1=3.
//  3. mem_rd=wb_rd=8, mem_result=0xA, wb_result=0xB, ex rs=8 -> ex_in1=0xA; mem_RegWrite=0 -> 0xB;
//     rd=0 -> registered data.
//  4. lw $t0 in EX, ID add uses rs=$t0 -> load_use_stall=1, next edge ex_valid=0, stall drops.
//  5. stall=1 with wb write to held rt=9 value 0x77 -> after release ex_store_data=0x77;
//     flush+stall same edge -> bubble.
//  6. reset asserted mid-stream between edges -> all outputs 0 immediately, ex_valid=0.

Source files
------------

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the 5-stage MIPS core datapath.
//   alu_ctl_e : ALU operation encodings driven on ALUCtl
//   fwd_src_e : operand source select used by the forwarding muxes
//   ctrl_t    : pipeline control bits carried through ID/EX
//   BUBBLE    : control value of an inserted bubble (no side effects)
//   imm_ext() : 16 -> 32 bit immediate expansion (lui / sign / zero)
// ---------------------------------------------------------------------------
package mips_pkg;

  typedef enum logic [4:0] {
    ALU_AND = 5'b00000,
    ALU_OR  = 5'b00001,
    ALU_ADD = 5'b00010,
    ALU_SUB = 5'b00110,
    ALU_SLT = 5'b00111,
    ALU_NOR = 5'b01100,
    ALU_XOR = 5'b01101,
    ALU_SLL = 5'b10000,
    ALU_SRL = 5'b11000,
    ALU_SRA = 5'b11001
  } alu_ctl_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_src_e;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '{valid: 1'b0, reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0};

  // LuOp takes precedence over ExtOp: lui always places imm16 in the upper half.
  function automatic logic [31:0] imm_ext(input logic [15:0] imm16,
                                          input logic        ext_op,
                                          input logic        lu_op);
    logic [31:0] r;
    if (lu_op) begin
      r = {imm16, 16'h0000};
    end else if (ext_op) begin
      r = {{16{imm16[15]}}, imm16};
    end else begin
      r = {16'h0000, imm16};
    end
    return r;
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// ---------------------------------------------------------------------------
// fwd_sel
// Forwarding mux for one source operand of the instruction in EX.
//   addr_i       : register address the operand was read from
//   reg_data_i   : value captured from the register file
//   mem_we_i / mem_rd_i / mem_result_i : EX/MEM producer
//   wb_we_i  / wb_rd_i  / wb_result_i  : MEM/WB producer
//   data_o       : operand value after forwarding
//   wb_hit_o     : the WB producer targets this operand (used by the
//                  parent to refresh held data while stalled)
// The younger producer (MEM) wins over WB; register 0 is never forwarded.
// ---------------------------------------------------------------------------
module fwd_sel
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic [RW-1:0] addr_i,
  input  logic [DW-1:0] reg_data_i,
  input  logic          mem_we_i,
  input  logic [RW-1:0] mem_rd_i,
  input  logic [DW-1:0] mem_result_i,
  input  logic          wb_we_i,
  input  logic [RW-1:0] wb_rd_i,
  input  logic [DW-1:0] wb_result_i,
  output logic [DW-1:0] data_o,
  output logic          wb_hit_o
);

  logic     mem_hit;
  fwd_src_e sel;

  assign mem_hit  = mem_we_i && (mem_rd_i != '0) && (mem_rd_i == addr_i);
  assign wb_hit_o = wb_we_i  && (wb_rd_i  != '0) && (wb_rd_i  == addr_i);

  always_comb begin
    sel = FWD_REG;
    if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit_o) begin
      sel = FWD_WB;
    end
  end

  always_comb begin
    data_o = reg_data_i;
    case (sel)
      FWD_MEM: data_o = mem_result_i;
      FWD_WB:  data_o = wb_result_i;
      default: data_o = reg_data_i;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register plus EX-side ALU operand assembly.
// Inputs:
//   clk, reset (async, active-high)
//   id_*            : decoded instruction fields from ID
//   stall           : hold ID/EX contents (downstream wait)
//   flush           : replace ID/EX contents with a bubble
//   mem_* / wb_*    : forwarding sources (EX/MEM and MEM/WB)
// Outputs:
//   ex_in1/ex_in2, ex_ALUCtl/ex_Sign : ALU operands and control
//   ex_store_data   : forwarded rt value for stores
//   ex_rd, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_valid
//   load_use_stall  : combinational; upstream holds PC and IF/ID
// Edge priority: flush > stall > load-use bubble > normal load.
// ---------------------------------------------------------------------------
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [RW-1:0] id_rs_addr,
  input  logic [RW-1:0] id_rt_addr,
  input  logic [RW-1:0] id_rd_addr,
  input  logic          id_uses_rs,
  input  logic          id_uses_rt,
  input  logic [15:0]   id_imm16,
  input  logic [4:0]    id_shamt,
  input  logic [4:0]    id_ALUCtl,
  input  logic          id_Sign,
  input  logic          id_ALUSrc1,
  input  logic          id_ALUSrc2,
  input  logic          id_ExtOp,
  input  logic          id_LuOp,
  input  logic          id_RegWrite,
  input  logic          id_MemRead,
  input  logic          id_MemWrite,
  input  logic          stall,
  input  logic          flush,
  input  logic          mem_RegWrite,
  input  logic [RW-1:0] mem_rd,
  input  logic [DW-1:0] mem_result,
  input  logic          wb_RegWrite,
  input  logic [RW-1:0] wb_rd,
  input  logic [DW-1:0] wb_result,
  output logic [DW-1:0] ex_in1,
  output logic [DW-1:0] ex_in2,
  output logic [4:0]    ex_ALUCtl,
  output logic          ex_Sign,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_rd,
  output logic          ex_RegWrite,
  output logic          ex_MemRead,
  output logic          ex_MemWrite,
  output logic          ex_valid,
  output logic          load_use_stall
);

  // ID/EX register state
  ctrl_t         ctrl_q,     ctrl_d;
  logic [DW-1:0] rs_data_q,  rs_data_d;
  logic [DW-1:0] rt_data_q,  rt_data_d;
  logic [RW-1:0] rs_addr_q,  rs_addr_d;
  logic [RW-1:0] rt_addr_q,  rt_addr_d;
  logic [RW-1:0] rd_q,       rd_d;
  logic [DW-1:0] imm32_q,    imm32_d;
  logic [4:0]    shamt_q,    shamt_d;
  logic [4:0]    alu_ctl_q,  alu_ctl_d;
  logic          sign_q,     sign_d;
  logic          alu_src1_q, alu_src1_d;
  logic          alu_src2_q, alu_src2_d;

  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;
  logic          rs_wb_hit;
  logic          rt_wb_hit;
  logic [DW-1:0] imm_id;
  logic          insert_bubble;

  // Immediate is expanded in ID so EX only sees a plain operand.
  assign imm_id = DW'(imm_ext(id_imm16, id_ExtOp, id_LuOp));

  // A load in EX whose destination is read by the instruction in ID cannot
  // be satisfied by forwarding: the data only exists after MEM.
  assign load_use_stall = ctrl_q.valid && ctrl_q.mem_read && (rd_q != '0) &&
                          ((id_uses_rs && (rd_q == id_rs_addr)) ||
                           (id_uses_rt && (rd_q == id_rt_addr)));

  // A stall holds the current contents even if a load-use hazard exists.
  assign insert_bubble = flush || (!stall && load_use_stall);

  fwd_sel #(.DW(DW), .RW(RW)) u_fwd_rs (
    .addr_i       (rs_addr_q),
    .reg_data_i   (rs_data_q),
    .mem_we_i     (mem_RegWrite),
    .mem_rd_i     (mem_rd),
    .mem_result_i (mem_result),
    .wb_we_i      (wb_RegWrite),
    .wb_rd_i      (wb_rd),
    .wb_result_i  (wb_result),
    .data_o       (fwd_rs),
    .wb_hit_o     (rs_wb_hit)
  );

  fwd_sel #(.DW(DW), .RW(RW)) u_fwd_rt (
    .addr_i       (rt_addr_q),
    .reg_data_i   (rt_data_q),
    .mem_we_i     (mem_RegWrite),
    .mem_rd_i     (mem_rd),
    .mem_result_i (mem_result),
    .wb_we_i      (wb_RegWrite),
    .wb_rd_i      (wb_rd),
    .wb_result_i  (wb_result),
    .data_o       (fwd_rt),
    .wb_hit_o     (rt_wb_hit)
  );

  always_comb begin
    ctrl_d     = ctrl_q;
    rs_data_d  = rs_data_q;
    rt_data_d  = rt_data_q;
    rs_addr_d  = rs_addr_q;
    rt_addr_d  = rt_addr_q;
    rd_d       = rd_q;
    imm32_d    = imm32_q;
    shamt_d    = shamt_q;
    alu_ctl_d  = alu_ctl_q;
    sign_d     = sign_q;
    alu_src1_d = alu_src1_q;
    alu_src2_d = alu_src2_q;

    if (insert_bubble) begin
      ctrl_d     = BUBBLE;
      rs_data_d  = '0;
      rt_data_d  = '0;
      rs_addr_d  = '0;
      rt_addr_d  = '0;
      rd_d       = '0;
      imm32_d    = '0;
      shamt_d    = '0;
      alu_ctl_d  = ALU_AND;
      sign_d     = 1'b0;
      alu_src1_d = 1'b0;
      alu_src2_d = 1'b0;
    end else if (stall) begin
      // A WB producer retiring while we are held would otherwise be lost:
      // once it leaves WB nothing can forward it any more.
      if (rs_wb_hit) begin
        rs_data_d = wb_result;
      end
      if (rt_wb_hit) begin
        rt_data_d = wb_result;
      end
    end else begin
      ctrl_d.valid     = id_valid;
      ctrl_d.reg_write = id_valid && id_RegWrite;
      ctrl_d.mem_read  = id_valid && id_MemRead;
      ctrl_d.mem_write = id_valid && id_MemWrite;
      rs_data_d        = id_rs_data;
      rt_data_d        = id_rt_data;
      rs_addr_d        = id_rs_addr;
      rt_addr_d        = id_rt_addr;
      rd_d             = id_rd_addr;
      imm32_d          = imm_id;
      shamt_d          = id_shamt;
      alu_ctl_d        = id_ALUCtl;
      sign_d           = id_Sign;
      alu_src1_d       = id_ALUSrc1;
      alu_src2_d       = id_ALUSrc2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q     <= BUBBLE;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      rs_addr_q  <= '0;
      rt_addr_q  <= '0;
      rd_q       <= '0;
      imm32_q    <= '0;
      shamt_q    <= '0;
      alu_ctl_q  <= ALU_AND;
      sign_q     <= 1'b0;
      alu_src1_q <= 1'b0;
      alu_src2_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      rs_addr_q  <= rs_addr_d;
      rt_addr_q  <= rt_addr_d;
      rd_q       <= rd_d;
      imm32_q    <= imm32_d;
      shamt_q    <= shamt_d;
      alu_ctl_q  <= alu_ctl_d;
      sign_q     <= sign_d;
      alu_src1_q <= alu_src1_d;
      alu_src2_q <= alu_src2_d;
    end
  end

  assign ex_in1        = alu_src1_q ? {{(DW-5){1'b0}}, shamt_q} : fwd_rs;
  assign ex_in2        = alu_src2_q ? imm32_q : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ex_ALUCtl     = alu_ctl_q;
  assign ex_Sign       = sign_q;
  assign ex_rd         = rd_q;
  assign ex_RegWrite   = ctrl_q.reg_write;
  assign ex_MemRead    = ctrl_q.mem_read;
  assign ex_MemWrite   = ctrl_q.mem_write;
  assign ex_valid      = ctrl_q.valid;

endmodule
